// File: rtl/sync_updown_cnt_pkg.sv
// Shared constants for the synchronous up/down counter.
package sync_updown_cnt_pkg;

    // Direction encoding on the up input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Range-end behaviour selected by the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/tff_cell.sv
// One counter bit: toggle flop with synchronous parallel load.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q
);

    // Load wins over toggle; neither asserted means hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= 1'b0;
        else if (ld) q <= d;
        else if (t)  q <= ~q;
    end

endmodule

// File: rtl/sync_updown_cnt.sv
// Fully synchronous loadable up/down counter, range 0..MODULUS-1,
// with terminal-count and registered wrap pulse.
module sync_updown_cnt
    import sync_updown_cnt_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cnt,
    output logic             q,
    output logic             qbar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(MODULUS - 1);
    // One bit wider so the clamp compare stays meaningful when MODULUS == 2**WIDTH
    localparam logic [WIDTH:0]   CNT_MAX_X = (WIDTH+1)'(MODULUS - 1);
    localparam logic             WRAP_MODE = (SATURATE == MODE_WRAP);

    logic [WIDTH-1:0] tog_up, tog_dn, t, ld_val;
    logic             ld, at_end;

    // Toggle chains: bit i flips when all lower bits are 1 (up) or all 0 (down)
    always_comb begin
        tog_up    = '0;
        tog_dn    = '0;
        tog_up[0] = 1'b1;
        tog_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            tog_up[i] = tog_up[i-1] & cnt[i-1];
            tog_dn[i] = tog_dn[i-1] & ~cnt[i-1];
        end
    end

    // Range end in the current direction; tc flags the edge that wraps or saturates
    assign at_end = (up == DIR_UP) ? (cnt == CNT_MAX) : (cnt == '0);
    assign tc     = en & ~load & at_end;

    // Next-state select: clamped load, range-end override, or plain toggle
    always_comb begin
        ld     = 1'b0;
        ld_val = '0;
        t      = '0;
        if (load) begin
            ld     = 1'b1;
            ld_val = ({1'b0, din} > CNT_MAX_X) ? CNT_MAX : din;
        end else if (en) begin
            if (at_end) begin
                // Saturate mode leaves t and ld clear, so the count holds
                if (WRAP_MODE) begin
                    ld     = 1'b1;
                    ld_val = (up == DIR_UP) ? '0 : CNT_MAX;
                end
            end else begin
                t = (up == DIR_UP) ? tog_up : tog_dn;
            end
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            tff_cell u_bit (
                .clk   (clk),
                .rst_n (rst_n),
                .ld    (ld),
                .d     (ld_val[i]),
                .t     (t[i]),
                .q     (cnt[i])
            );
        end
    endgenerate

    // Wrap pulse: high for one cycle after a range-end crossing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wrap <= 1'b0;
        else        wrap <= tc & WRAP_MODE;
    end

    assign q    = cnt[WIDTH-1];
    assign qbar = ~cnt[WIDTH-1];

endmodule

// File: tb/tb_sync_updown_cnt.sv
// Bench for sync_updown_cnt: three configurations driven in lockstep
// (mod-16 wrap, mod-10 wrap, mod-16 saturate) against an integer model.
module tb_sync_updown_cnt;

    localparam int N = 3;
    localparam int MODS [N] = '{16, 10, 16};
    localparam int SATS [N] = '{0, 0, 1};

    logic       clk, rst_n, en, up, load;
    logic [3:0] din;
    logic [3:0] cnt_o [N];
    logic       q_o [N], qbar_o [N], tc_o [N], wrap_o [N];

    int m_cnt [N];
    int m_wrap [N];
    int errs = 0;
    int checks = 0;

    sync_updown_cnt #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_m16 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din),
        .cnt(cnt_o[0]), .q(q_o[0]), .qbar(qbar_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]));
    sync_updown_cnt #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_m10 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din),
        .cnt(cnt_o[1]), .q(q_o[1]), .qbar(qbar_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]));
    sync_updown_cnt #(.WIDTH(4), .MODULUS(16), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din),
        .cnt(cnt_o[2]), .q(q_o[2]), .qbar(qbar_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_tc(input int i, input logic e, input logic u, input logic l);
        int at_end;
        at_end = u ? (m_cnt[i] == MODS[i] - 1) : (m_cnt[i] == 0);
        return (e && !l && at_end) ? 1 : 0;
    endfunction

    // Advance one configuration's model by one clock edge
    task automatic model_step(input int i, input logic e, input logic u, input logic l, input int d);
        int top;
        top = MODS[i] - 1;
        m_wrap[i] = 0;
        if (l) begin
            m_cnt[i] = (d > top) ? top : d;
        end else if (e) begin
            if (u) begin
                if (m_cnt[i] < top)   m_cnt[i] = m_cnt[i] + 1;
                else if (SATS[i] == 0) begin m_cnt[i] = 0; m_wrap[i] = 1; end
            end else begin
                if (m_cnt[i] > 0)     m_cnt[i] = m_cnt[i] - 1;
                else if (SATS[i] == 0) begin m_cnt[i] = top; m_wrap[i] = 1; end
            end
        end
    endtask

    task automatic check_state(input string what);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s cnt[%0d]", what, i), int'(cnt_o[i]), m_cnt[i]);
            chk($sformatf("%s wrap[%0d]", what, i), int'(wrap_o[i]), m_wrap[i]);
            chk($sformatf("%s q[%0d]", what, i), int'(q_o[i]), (m_cnt[i] >> 3) & 1);
            chk($sformatf("%s qbar[%0d]", what, i), int'(qbar_o[i]), ((m_cnt[i] >> 3) & 1) ^ 1);
        end
    endtask

    // Called at a falling edge: drive, check tc, clock, check registered state
    task automatic step(input logic e, input logic u, input logic l, input logic [3:0] d);
        en = e; up = u; load = l; din = d;
        #1;
        for (int i = 0; i < N; i++)
            chk($sformatf("tc[%0d]", i), int'(tc_o[i]), model_tc(i, e, u, l));
        @(posedge clk);
        for (int i = 0; i < N; i++) model_step(i, e, u, l, int'(d));
        @(negedge clk);
        check_state("step");
    endtask

    // Pull reset low between edges and confirm the clear is immediate
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_wrap[i] = 0;
        end
        check_state("async");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; up = 1'b0; load = 1'b0; din = 4'd0;
        for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_wrap[i] = 0; end
        repeat (2) @(negedge clk);
        check_state("reset");
        for (int i = 0; i < N; i++)
            chk($sformatf("reset tc[%0d]", i), int'(tc_o[i]), 1);
        rst_n = 1'b1;

        // Down count from reset through the wrap
        repeat (17) step(1'b1, 1'b0, 1'b0, 4'd0);
        // Up count through the top end
        step(1'b0, 1'b1, 1'b1, 4'd0);
        repeat (17) step(1'b1, 1'b1, 1'b0, 4'd0);
        // Load and clamp, then down through zero
        step(1'b0, 1'b0, 1'b1, 4'd7);
        step(1'b0, 1'b0, 1'b1, 4'd12);
        repeat (12) step(1'b1, 1'b0, 1'b0, 4'd0);
        // Range ends held for several edges
        step(1'b0, 1'b0, 1'b1, 4'd1);
        repeat (6) step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b1, 4'd15);
        repeat (6) step(1'b1, 1'b1, 1'b0, 4'd0);
        // Load beats enable, hold, then alternate direction
        step(1'b1, 1'b0, 1'b1, 4'd5);
        repeat (3) step(1'b0, 1'b1, 1'b0, 4'd0);
        repeat (2) begin
            step(1'b1, 1'b1, 1'b0, 4'd0);
            step(1'b1, 1'b0, 1'b0, 4'd0);
        end
        // Async reset with wrap high, then mid-count
        step(1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        async_reset();
        step(1'b0, 1'b0, 1'b1, 4'd11);
        async_reset();

        // Random traffic
        repeat (400) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
